// File: rtl/dvi_bw_pkg.sv
// rtl/dvi_bw_pkg.sv - shared types, default 640x480 timing and helpers for dvi_bw_timing_ctrl
//
// Purpose: raster phase enum, default timing constants, and constant functions
//          used to size counters and the per-line fetch schedule.
// Ports:   none (package).
package dvi_bw_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_WORD_W   = 16;
    localparam int DEF_ADDR_W   = 15;

    function automatic int words_per_line(input int h_active, input int word_w);
        return h_active / word_w;
    endfunction

    // Width of a phase counter that must reach (longest phase - 1).
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/dvi_bw_timing_ctrl_if.sv
// rtl/dvi_bw_timing_ctrl_if.sv - framebuffer read bus between timing controller and RAM
//
// Purpose: groups the synchronous framebuffer read port.
// Signals: rd_en_o   read strobe (controller -> RAM), one clk wide
//          rd_addr_o word address (controller -> RAM)
//          rd_dat_i  read data (RAM -> controller), valid 1 clk after rd_en_o
// Modports: master = timing controller, slave = framebuffer RAM.
interface dvi_bw_timing_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 16
);
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [WORD_W-1:0] rd_dat_i;

    modport master (output rd_en_o, output rd_addr_o, input rd_dat_i);
    modport slave  (input rd_en_o, input rd_addr_o, output rd_dat_i);
endinterface

// File: rtl/dvi_bw_phase_cnt.sv
// rtl/dvi_bw_phase_cnt.sv - ACTIVE/FP/SYNC/BP phase FSM with per-phase counter
//
// Purpose: one raster axis (used for both horizontal and vertical).
// Ports:   clk_i, rst_ni (sync active-low), adv_i (advance one unit),
//          phase_o (current phase), cnt_o (index within phase),
//          wrap_o (current unit is the last one of BP, i.e. end of the period).
module dvi_bw_phase_cnt
    import dvi_bw_pkg::*;
#(
    parameter int LEN_ACTIVE = 640,
    parameter int LEN_FP     = 16,
    parameter int LEN_SYNC   = 96,
    parameter int LEN_BP     = 48,
    parameter int CNT_W      = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    output phase_e           phase_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] last;
    phase_e           nxt;

    always_comb begin
        last = CNT_W'(LEN_ACTIVE - 1);
        nxt  = PH_FP;
        case (phase_o)
            PH_FP:   begin last = CNT_W'(LEN_FP - 1);   nxt = PH_SYNC;   end
            PH_SYNC: begin last = CNT_W'(LEN_SYNC - 1); nxt = PH_BP;     end
            PH_BP:   begin last = CNT_W'(LEN_BP - 1);   nxt = PH_ACTIVE; end
            default: ;
        endcase
    end

    assign wrap_o = (phase_o == PH_BP) && (cnt_o == last);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase_o <= PH_ACTIVE;
            cnt_o   <= '0;
        end else if (adv_i) begin
            if (cnt_o == last) begin
                cnt_o   <= '0;
                phase_o <= nxt;
            end else begin
                cnt_o <= cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dvi_bw_timing_ctrl.sv
// rtl/dvi_bw_timing_ctrl.sv - 1-bpp DVI raster sequencer with framebuffer prefetch
//
// Purpose: generates DE/sync/coordinates on each pixel strobe and unpacks
//          1-bpp framebuffer words into the serializer pixel bit.
// Optional: DVI_BW_TEST_PATTERN_EN adds tp_en_i (8x8 checkerboard, no reads).
// Ports:   clk_i, rst_ni (sync active-low), ce_i (pixel strobe),
//          fb (framebuffer read bus, master), de_o, dat_o, hsync_o, vsync_o,
//          x_o, y_o (active coordinates), sof_o (start-of-frame pulse),
//          tp_en_i (only with DVI_BW_TEST_PATTERN_EN).
module dvi_bw_timing_ctrl
    import dvi_bw_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int WORD_W   = DEF_WORD_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        ce_i,
`ifdef DVI_BW_TEST_PATTERN_EN
    input  logic                        tp_en_i,
`endif
    dvi_bw_timing_ctrl_if.master        fb,
    output logic                        de_o,
    output logic                        dat_o,
    output logic                        hsync_o,
    output logic                        vsync_o,
    output logic [$clog2(H_ACTIVE)-1:0] x_o,
    output logic [$clog2(V_ACTIVE)-1:0] y_o,
    output logic                        sof_o
);

    localparam int HCW = cnt_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VCW = cnt_width(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int WPL = words_per_line(H_ACTIVE, WORD_W);
    localparam int XW  = $clog2(H_ACTIVE);
    localparam int YW  = $clog2(V_ACTIVE);

    if (H_ACTIVE % WORD_W != 0) begin : g_chk_word
        $fatal(1, "H_ACTIVE must be a multiple of WORD_W");
    end
    if ((2 ** ADDR_W) < (H_ACTIVE * V_ACTIVE / WORD_W)) begin : g_chk_addr
        $fatal(1, "ADDR_W too small for one frame");
    end

    phase_e           h_ph, v_ph;
    logic [HCW-1:0]   h_cnt;
    logic [VCW-1:0]   v_cnt;
    logic             h_wrap, v_wrap, v_adv;

    dvi_bw_phase_cnt #(
        .LEN_ACTIVE(H_ACTIVE), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP), .CNT_W(HCW)
    ) u_h (
        .clk_i(clk_i), .rst_ni(rst_ni), .adv_i(ce_i),
        .phase_o(h_ph), .cnt_o(h_cnt), .wrap_o(h_wrap)
    );

    assign v_adv = ce_i & h_wrap;

    dvi_bw_phase_cnt #(
        .LEN_ACTIVE(V_ACTIVE), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP), .CNT_W(VCW)
    ) u_v (
        .clk_i(clk_i), .rst_ni(rst_ni), .adv_i(v_adv),
        .phase_o(v_ph), .cnt_o(v_cnt), .wrap_o(v_wrap)
    );

    logic              h_act, v_act, pix_de, first_pix;
    logic              next_line_active, bp_fetch, grp_start, grp_fetch, sync_entry;
    logic              rd_en_q, rd_pend, data_ok;
    logic [ADDR_W-1:0] rd_addr_q, addr_cnt;
    logic [WORD_W-1:0] pf, sreg, sreg_nxt;
    logic              pix_bit, pix_dat, tp_now;

    assign h_act     = (h_ph == PH_ACTIVE);
    assign v_act     = (v_ph == PH_ACTIVE);
    assign pix_de    = h_act && v_act;
    assign first_pix = pix_de && (h_cnt == '0) && (v_cnt == '0);

    // The BP prefetch serves the following line, so it is gated by whether
    // that line is active: any active line but the last, or the final V_BP line.
    assign next_line_active = (v_act && (v_cnt != VCW'(V_ACTIVE - 1))) || v_wrap;
    assign bp_fetch   = (h_ph == PH_BP) && (h_cnt == '0) && next_line_active;
    assign grp_start  = pix_de && ((h_cnt % HCW'(WORD_W)) == '0);
    assign grp_fetch  = grp_start && (h_cnt < HCW'((WPL - 1) * WORD_W));
    assign sync_entry = v_adv && (v_ph == PH_FP) && (v_cnt == VCW'(V_FP - 1));

    // At a group start the fresh word is consumed directly so bit 0 goes out
    // on the same pixel as the load.
    always_comb begin
        pix_bit  = sreg[0];
        sreg_nxt = sreg >> 1;
        if (grp_start) begin
            pix_bit  = pf[0];
            sreg_nxt = pf >> 1;
        end
    end

`ifdef DVI_BW_TEST_PATTERN_EN
    logic tp_q;
    // The latch takes effect on the sof pixel itself so that pixel's fetch is suppressed too.
    assign tp_now  = first_pix ? tp_en_i : tp_q;
    assign pix_dat = tp_now ? (h_cnt[3] ^ v_cnt[3]) : (data_ok & pix_bit);

    always_ff @(posedge clk_i) begin
        if (!rst_ni)                tp_q <= 1'b0;
        else if (ce_i && first_pix) tp_q <= tp_en_i;
    end
`else
    assign tp_now  = 1'b0;
    assign pix_dat = data_ok & pix_bit;
`endif

    assign fb.rd_en_o   = rd_en_q;
    assign fb.rd_addr_o = rd_addr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            de_o      <= 1'b0;
            dat_o     <= 1'b0;
            hsync_o   <= 1'b0;
            vsync_o   <= 1'b0;
            x_o       <= '0;
            y_o       <= '0;
            sof_o     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_pend   <= 1'b0;
            addr_cnt  <= '0;
            pf        <= '0;
            sreg      <= '0;
            data_ok   <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            sof_o   <= 1'b0;
            rd_pend <= rd_en_q;
            if (rd_pend) pf <= fb.rd_dat_i;
            if (ce_i) begin
                de_o    <= pix_de;
                dat_o   <= pix_de & pix_dat;
                hsync_o <= (h_ph == PH_SYNC);
                vsync_o <= (v_ph == PH_SYNC);
                x_o     <= h_act ? h_cnt[XW-1:0] : '0;
                y_o     <= v_act ? v_cnt[YW-1:0] : '0;
                sof_o   <= first_pix;
                if (pix_de) sreg <= sreg_nxt;
                if ((bp_fetch || grp_fetch) && !tp_now) begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= addr_cnt;
                    addr_cnt  <= addr_cnt + 1'b1;
                end
                // Data becomes trustworthy once a full vertical blank (and
                // hence the line-0 prefetch) lies ahead.
                if (sync_entry) begin
                    addr_cnt <= '0;
                    data_ok  <= 1'b1;
                end
            end
        end
    end

    // A pixel strobe must never land on the clk that is still issuing a read.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(ce_i && rd_en_q));

endmodule

// File: tb/tb_dvi_bw_timing_ctrl.sv
// tb/tb_dvi_bw_timing_ctrl.sv - directed self-checking bench for dvi_bw_timing_ctrl
module tb_dvi_bw_timing_ctrl;

    localparam int HA = 32, HFP = 4, HS = 6, HBP = 6, HT = HA + HFP + HS + HBP;
    localparam int VA = 16, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
    localparam int WW = 16, AW = 6, WPL = HA / WW;

    logic       clk = 1'b0, rst_n = 1'b0, ce = 1'b0, tp_en = 1'b0;
    logic       de, dat, hs, vs, sof;
    logic [4:0] x;
    logic [3:0] y;
    logic [WW-1:0] mem [0:(1<<AW)-1];

    int tests = 0, fails = 0, exp_addr = 0, sof_cnt = 0, frames = 0;

    dvi_bw_timing_ctrl_if #(.ADDR_W(AW), .WORD_W(WW)) fb ();

    dvi_bw_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .WORD_W(WW), .ADDR_W(AW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce),
`ifdef DVI_BW_TEST_PATTERN_EN
        .tp_en_i(tp_en),
`endif
        .fb(fb.master),
        .de_o(de), .dat_o(dat), .hsync_o(hs), .vsync_o(vs),
        .x_o(x), .y_o(y), .sof_o(sof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (fb.rd_en_o) fb.rd_dat_i <= mem[fb.rd_addr_o];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Five clk per pixel; outputs sampled on the negedge right after the ce edge.
    task automatic do_ce();
        @(negedge clk);
        check("pulse_width", {30'd0, fb.rd_en_o, sof}, 32'd0);
        repeat (3) @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        if (sof) sof_cnt++;
    endtask

    task automatic run_frame(input bit valid, input bit tp,
                             input logic [WW-1:0] w0_cur, input logic [WW-1:0] w0_next);
        int rd_cnt;
        rd_cnt = 0;
        frames++;
        for (int line = 0; line < VT; line++) begin
            for (int pix = 0; pix < HT; pix++) begin
                logic          de_e, dat_e, rd_e;
                logic [WW-1:0] w;
                int            g;
                if (line == VA + VFP && pix == 0) exp_addr = 0;
                if (line == VA && pix == 0) mem[0] = w0_next;
                do_ce();
                de_e = (pix < HA) && (line < VA);
                check("de", de, de_e);
                check("hsync", hs, (pix >= HA + HFP) && (pix < HA + HFP + HS));
                check("vsync", vs, (line >= VA + VFP) && (line < VA + VFP + VS));
                check("sof", sof, (line == 0) && (pix == 0));
                dat_e = 1'b0;
                if (de_e) begin
                    check("x", x, pix);
                    check("y", y, line);
                    g = line * WPL + pix / WW;
                    w = (g == 0) ? w0_cur : WW'(g);
                    if (tp)         dat_e = pix[3] ^ line[3];
                    else if (valid) dat_e = w[pix % WW];
                end
                check("dat", dat, dat_e);
                rd_e = !tp && (((pix == HA + HFP + HS) && (line < VA - 1 || line == VT - 1)) ||
                               (de_e && (pix % WW == 0) && (pix < HA - WW)));
                check("rd_en", fb.rd_en_o, rd_e);
                if (rd_e) begin
                    check("rd_addr", fb.rd_addr_o, exp_addr);
                    exp_addr++;
                end
                if (fb.rd_en_o) rd_cnt++;
            end
        end
        check("rd_per_frame", rd_cnt, tp ? 0 : VA * WPL);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = WW'(i);
        mem[0] = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_de", de, 0);
        check("rst_dat", dat, 0);
        check("rst_hsync", hs, 0);
        check("rst_vsync", vs, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_sof", sof, 0);
        check("rst_rd_en", fb.rd_en_o, 0);
        check("rst_rd_addr", fb.rd_addr_o, 0);
        rst_n = 1'b1;
        exp_addr = 0;

        run_frame(1'b0, 1'b0, 16'h0000, 16'h0001);
        run_frame(1'b1, 1'b0, 16'h0001, 16'h8000);
        run_frame(1'b1, 1'b0, 16'h8000, 16'h0000);

        frames++;
        for (int i = 0; i < 5 * HT + 20; i++) do_ce();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        exp_addr = 0;
        run_frame(1'b0, 1'b0, 16'h0000, 16'h0001);
        run_frame(1'b1, 1'b0, 16'h0001, 16'h0000);

`ifdef DVI_BW_TEST_PATTERN_EN
        tp_en = 1'b1;
        run_frame(1'b1, 1'b1, 16'h0000, 16'h0000);
`endif

        check("sof_count", sof_cnt, frames);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
